// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front-end reader for the instruction memory. Owns the fetch PC, drives the
// byte read address, samples the combinationally returned word into a small
// prefetch queue tagged with its PC, and hands entries to decode over a
// valid/ready handshake. Supports redirect (flush + refetch) and stops
// fetching once a halt opcode has been enqueued.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high reset
//   readAddress     out  byte address to instruction memory (= fetch PC)
//   readData        in   instruction word for readAddress (combinational)
//   instr_out       out  instruction at queue head
//   pc_out          out  byte address of instr_out
//   instr_valid     out  queue head holds a valid instruction
//   instr_ready     in   decode accepts the head this cycle
//   redirect        in   one-cycle pulse: flush and refetch from target
//   redirect_target in   new byte PC (bit 0 forced to 0)
//   halted          out  halt word fetched, fetching stopped
//   perf_fetched    out  saturating count of pushes      (FETCH_PERF_EN only)
//   perf_stall      out  saturating count of valid&!ready (FETCH_PERF_EN only)
//
// Optional feature macro: FETCH_PERF_EN
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int          DEPTH       = 2,
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hE
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] readAddress,
   input  logic [15:0] readData,
   output logic [15:0] instr_out,
   output logic [15:0] pc_out,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_target,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_stall
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [15:0]   pc_q;
   logic [15:0]   instr_mem_q [DEPTH];
   logic [15:0]   pc_mem_q    [DEPTH];
   logic [PW-1:0] rd_q, wr_q, rd_nxt;
   logic [CW-1:0] cnt_q;
   logic          halted_q;
   logic [15:0]   out_instr_q, out_pc_q;
   logic          full, pop, push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   // Redirect overrides both queue operations; a head accepted in the
   // redirect cycle disappears with the flush rather than via a pop.
   always_comb begin
      full   = (cnt_q == CW'(DEPTH));
      pop    = (cnt_q != '0) && instr_ready && !redirect;
      push   = !halted_q && !redirect && (!full || pop);
      rd_nxt = ptr_inc(rd_q);
   end

   // Queue storage carries no reset: occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_q] <= readData;
         pc_mem_q[wr_q]    <= pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         rd_q        <= '0;
         wr_q        <= '0;
         cnt_q       <= '0;
         halted_q    <= 1'b0;
         out_instr_q <= 16'h0000;
         out_pc_q    <= 16'h0000;
      end else if (redirect) begin
         pc_q     <= redirect_target & 16'hFFFE;
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         if (push) begin
            wr_q <= ptr_inc(wr_q);
            pc_q <= pc_q + 16'd2;
            if (readData[15:12] == HALT_OPCODE) halted_q <= 1'b1;
         end
         if (pop) rd_q <= rd_nxt;
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
         // Head registers mirror the entry that will sit at the head after
         // this edge; when the queue drains they keep the last delivered
         // entry.
         if (pop) begin
            if (cnt_q >= CW'(2)) begin
               out_instr_q <= instr_mem_q[rd_nxt];
               out_pc_q    <= pc_mem_q[rd_nxt];
            end else if (push) begin
               out_instr_q <= readData;
               out_pc_q    <= pc_q;
            end
         end else if (cnt_q == '0 && push) begin
            out_instr_q <= readData;
            out_pc_q    <= pc_q;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched_q, perf_stall_q;

   // Counters survive redirect; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q <= 16'h0000;
         perf_stall_q   <= 16'h0000;
      end else begin
         if (push) perf_fetched_q <= sat_inc(perf_fetched_q);
         if ((cnt_q != '0) && !instr_ready) perf_stall_q <= sat_inc(perf_stall_q);
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

   assign readAddress = pc_q;
   assign instr_out   = out_instr_q;
   assign pc_out      = out_pc_q;
   assign instr_valid = (cnt_q != '0);
   assign halted      = halted_q;

endmodule
